fir_stream_adapter: RTL

- Host-side driver for the FIR datapath controller.
- Accepts samples on a valid/ready upstream stream and issues each one to the FIR as a single-cycle input-valid pulse with the sample held stable.
- Waits for the FIR output-valid pulse, captures the filtered result, and presents it on a valid/ready downstream stream.
- Sits between the sample source (ADC/FIFO) and the result sink; exactly one sample is in flight in the FIR at a time.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_watchdog.sv | 36 +++
 rtl/fir_stream_adapter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and default sizing for the FIR stream adapter and its watchdog.
package fir_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int COEF_W_DEF   = 16;
    localparam int FIR_SIZE_DEF = 64;

    // Full-precision accumulator width: sample + coefficient + tap-sum growth.
    function automatic int fir_out_w(input int data_w, input int coef_w, input int fir_size);
        return data_w + coef_w + $clog2(fir_size);
    endfunction

    localparam int OUT_W_DEF = fir_out_w(DATA_W_DEF, COEF_W_DEF, FIR_SIZE_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } fir_state_e;

endpackage

// File: rtl/fir_watchdog.sv
// Cycle counter that flags an expired FIR response; counts while enabled, saturates at TIMEOUT.
module fir_watchdog #(
    parameter int TIMEOUT = 72
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/fir_stream_adapter.sv
// Valid/ready front end for the FIR controller: one sample in flight, result held until accepted.
// Optional watchdog with sticky err output is enabled by defining FIR_TIMEOUT_EN.
module fir_stream_adapter
    import fir_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int FIR_SIZE = FIR_SIZE_DEF,
    parameter int OUT_W    = fir_out_w(DATA_W, COEF_W_DEF, FIR_SIZE)
`ifdef FIR_TIMEOUT_EN
    ,
    parameter int TIMEOUT  = FIR_SIZE + 8
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              fir_input_valid,
    output logic [DATA_W-1:0] fir_data_in,
    input  logic              fir_output_valid,
    input  logic [OUT_W-1:0]  fir_data_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OUT_W-1:0]  m_data,
    output logic              busy,
`ifdef FIR_TIMEOUT_EN
    output logic              err,
`endif
    output logic [15:0]       sample_cnt
);

    fir_state_e        state_q, state_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [OUT_W-1:0]  result_q, result_d;
    logic [15:0]       cnt_q, cnt_d;

`ifdef FIR_TIMEOUT_EN
    logic err_q, err_d;
    logic wd_expired;

    fir_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q == ST_ISSUE),
        .enable_i  (state_q == ST_WAIT),
        .expired_o (wd_expired)
    );

    assign err = err_q;
`endif

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        result_d = result_q;
        cnt_d    = cnt_q;
`ifdef FIR_TIMEOUT_EN
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    sample_d = s_data;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // A result arriving on the expiry cycle still counts as a normal capture.
                if (fir_output_valid) begin
                    result_d = fir_data_out;
                    state_d  = ST_HOLD;
                end
`ifdef FIR_TIMEOUT_EN
                else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_HOLD: begin
                if (m_ready) begin
                    cnt_d = cnt_q + 16'd1;
                    if (s_valid) begin
                        sample_d = s_data;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sample_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
`ifdef FIR_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
`ifdef FIR_TIMEOUT_EN
            err_q    <= err_d;
`endif
        end
    end

    // State already reads IDLE while rst is held, so ready is masked explicitly.
    assign s_ready         = ((state_q == ST_IDLE) && !rst) || ((state_q == ST_HOLD) && m_ready);
    assign fir_input_valid = (state_q == ST_ISSUE);
    assign fir_data_in     = sample_q;
    assign m_valid         = (state_q == ST_HOLD);
    assign m_data          = result_q;
    assign busy            = (state_q != ST_IDLE);
    assign sample_cnt      = cnt_q;

endmodule
